// File: rtl/pool_window_gen.sv
// Builds 3x3 windows from a raster-order pixel stream using two line buffers and a
// sliding register window; emits windows aligned to STRIDE for the pooling stage.
module pool_window_gen #(
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic signed [7:0] data_in,
    output logic signed [7:0] win0,
    output logic signed [7:0] win1,
    output logic signed [7:0] win2,
    output logic signed [7:0] win3,
    output logic signed [7:0] win4,
    output logic signed [7:0] win5,
    output logic signed [7:0] win6,
    output logic signed [7:0] win7,
    output logic signed [7:0] win8,
    output logic              valid_out,
    output logic              frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [PW-1:0]     xph_q, yph_q;
    logic signed [7:0] lb0 [IMG_W];
    logic signed [7:0] lb1 [IMG_W];
    logic signed [7:0] win_q [9];
    logic signed [7:0] win_d [9];
    logic signed [7:0] out_q [9];
    logic              valid_q, done_q;
    logic              last_col, last_row, win_ok;
    logic signed [7:0] lb0_rd, lb1_rd;
    logic [PW-1:0]     xph_step, yph_step;

    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));
    // Phases are only meaningful from col/row 2 onward, so they stay 0 before that.
    assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2)) && (xph_q == '0) && (yph_q == '0);
    assign xph_step = (xph_q == PW'(STRIDE - 1)) ? '0 : xph_q + 1'b1;
    assign yph_step = (yph_q == PW'(STRIDE - 1)) ? '0 : yph_q + 1'b1;

    // Combinational read ahead of the clocked write gives read-before-write.
    assign lb0_rd = lb0[col_q];
    assign lb1_rd = lb1[col_q];

    always_comb begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = lb1_rd;
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = lb0_rd;
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = data_in;
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb1[col_q] <= lb0_rd;
            lb0[col_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            xph_q   <= '0;
            yph_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_in && win_ok;
            done_q  <= valid_in && last_col && last_row;
            if (valid_in) begin
                for (int i = 0; i < 9; i++) begin
                    win_q[i] <= win_d[i];
                end
                if (win_ok) begin
                    for (int i = 0; i < 9; i++) begin
                        out_q[i] <= win_d[i];
                    end
                end
                if (last_col) begin
                    col_q <= '0;
                    xph_q <= '0;
                    if (last_row) begin
                        row_q <= '0;
                        yph_q <= '0;
                    end else begin
                        row_q <= row_q + 1'b1;
                        if (row_q >= RW'(2)) yph_q <= yph_step;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                    if (col_q >= CW'(2)) xph_q <= xph_step;
                end
            end
        end
    end

    assign win0       = out_q[0];
    assign win1       = out_q[1];
    assign win2       = out_q[2];
    assign win3       = out_q[3];
    assign win4       = out_q[4];
    assign win5       = out_q[5];
    assign win6       = out_q[6];
    assign win7       = out_q[7];
    assign win8       = out_q[8];
    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: a 4x4/stride-1 and a 5x5/stride-2 instance checked cycle by
// cycle against a frame-array reference model.
module tb_pool_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              va, vb;
    logic signed [7:0] da, db;
    logic [71:0]       a_win, b_win;
    logic              a_vo, a_fd, b_vo, b_fd;

    pool_window_gen #(.IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(va), .data_in(da),
        .win0(a_win[71:64]), .win1(a_win[63:56]), .win2(a_win[55:48]),
        .win3(a_win[47:40]), .win4(a_win[39:32]), .win5(a_win[31:24]),
        .win6(a_win[23:16]), .win7(a_win[15:8]), .win8(a_win[7:0]),
        .valid_out(a_vo), .frame_done(a_fd)
    );

    pool_window_gen #(.IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(vb), .data_in(db),
        .win0(b_win[71:64]), .win1(b_win[63:56]), .win2(b_win[55:48]),
        .win3(b_win[47:40]), .win4(b_win[39:32]), .win5(b_win[31:24]),
        .win6(b_win[23:16]), .win7(b_win[15:8]), .win8(b_win[7:0]),
        .valid_out(b_vo), .frame_done(b_fd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the current frame as a plain pixel array per instance.
    logic signed [7:0] img [2][64];
    int                mr [2];
    int                mc [2];
    logic [71:0]       last_w [2];

    function automatic int gw(input int id); return (id == 0) ? 4 : 5; endfunction
    function automatic int gh(input int id); return (id == 0) ? 4 : 5; endfunction
    function automatic int gs(input int id); return (id == 0) ? 1 : 2; endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            mr[id] = 0;
            mc[id] = 0;
            last_w[id] = '0;
        end
    endtask

    task automatic model_accept(input int id, input logic signed [7:0] d,
                                output bit ev, output bit efd);
        int w, h, s, r, c;
        logic [71:0] acc;
        w = gw(id); h = gh(id); s = gs(id);
        r = mr[id]; c = mc[id];
        img[id][r * w + c] = d;
        ev  = (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
        efd = (r == h - 1) && (c == w - 1);
        if (ev) begin
            acc = '0;
            for (int dr = 2; dr >= 0; dr--)
                for (int dc = 2; dc >= 0; dc--)
                    acc = {acc[63:0], img[id][(r - dr) * w + (c - dc)]};
            last_w[id] = acc;
        end
        c++;
        if (c == w) begin
            c = 0;
            r = (r == h - 1) ? 0 : r + 1;
        end
        mr[id] = r;
        mc[id] = c;
    endtask

    // One clock of stimulus on instance id; returns the observed and modelled outputs.
    task automatic drive_cycle(input int id, input bit v, input logic signed [7:0] d,
                               output bit ov, output bit ofd, output logic [71:0] ow,
                               output bit ev, output bit efd, output logic [71:0] ew);
        if (id == 0) begin va = v; da = d; end
        else begin vb = v; db = d; end
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        ev = 1'b0;
        efd = 1'b0;
        if (v) model_accept(id, d, ev, efd);
        ew  = last_w[id];
        ov  = (id == 0) ? a_vo : b_vo;
        ofd = (id == 0) ? a_fd : b_fd;
        ow  = (id == 0) ? a_win : b_win;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({a_vo, a_fd, b_vo, b_fd} !== 4'b0 || a_win !== '0 || b_win !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got vo=%0b fd=%0b win=%h, want 0 0 0", a_vo, a_fd, a_win);
        end
        @(posedge clk);
        #4 rst_n = 1'b1;
        #1;
        n_tests++;
        if ({a_vo, a_fd, b_vo, b_fd} !== 4'b0 || a_win !== '0 || b_win !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got vo=%0b fd=%0b win=%h, want 0 0 0",
                     b_vo, b_fd, b_win);
        end
    endtask

    task automatic test_stride1();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew, first_w, final_w;
        int np = 0;
        first_w = '0;
        final_w = '0;
        for (int k = 0; k < 16; k++) begin
            drive_cycle(0, 1'b1, 8'(k), ov, ofd, ow, ev, efd, ew);
            n_tests++;
            if (ov !== ev || ofd !== efd || ow !== ew) begin
                n_fail++;
                $display("FAIL stride1 k=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                         k, ov, ofd, ow, ev, efd, ew);
            end
            if (ov) begin
                if (np == 0) first_w = ow;
                final_w = ow;
                np++;
            end
        end
        n_tests++;
        if (np !== 4) begin
            n_fail++;
            $display("FAIL stride1_count: got %0d windows, want 4", np);
        end
        n_tests++;
        if (first_w !== 72'h00_01_02_04_05_06_08_09_0A) begin
            n_fail++;
            $display("FAIL stride1_first: got %h, want 000102040506080 90a", first_w);
        end
        n_tests++;
        if (final_w !== 72'h05_06_07_09_0A_0B_0D_0E_0F) begin
            n_fail++;
            $display("FAIL stride1_last: got %h, want 05060709 0a0b0d0e0f", final_w);
        end
    endtask

    task automatic test_stride2();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew, first_w;
        int w8q[$];
        int want8[4] = '{12, 14, 22, 24};
        first_w = '0;
        for (int k = 0; k < 25; k++) begin
            drive_cycle(1, 1'b1, 8'(k), ov, ofd, ow, ev, efd, ew);
            n_tests++;
            if (ov !== ev || ofd !== efd || ow !== ew) begin
                n_fail++;
                $display("FAIL stride2 k=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                         k, ov, ofd, ow, ev, efd, ew);
            end
            if (ov) begin
                if (w8q.size() == 0) first_w = ow;
                w8q.push_back(int'($signed(ow[7:0])));
            end
        end
        n_tests++;
        if (w8q.size() !== 4) begin
            n_fail++;
            $display("FAIL stride2_count: got %0d windows, want 4", w8q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (w8q[i] !== want8[i]) begin
                    n_fail++;
                    $display("FAIL stride2_win8[%0d]: got %0d, want %0d", i, w8q[i], want8[i]);
                end
            end
        end
        n_tests++;
        if (first_w !== 72'h00_01_02_05_06_07_0A_0B_0C) begin
            n_fail++;
            $display("FAIL stride2_first: got %h, want 000102050607 0a0b0c", first_w);
        end
    endtask

    task automatic test_gaps();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew;
        int np = 0;
        for (int k = 0; k < 16; k++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                drive_cycle(0, 1'b0, 8'sd0, ov, ofd, ow, ev, efd, ew);
                n_tests++;
                if (ov !== 1'b0 || ofd !== 1'b0 || ow !== ew) begin
                    n_fail++;
                    $display("FAIL gaps_idle k=%0d: got v=%0b fd=%0b win=%h, want v=0 fd=0 win=%h",
                             k, ov, ofd, ow, ew);
                end
            end
            drive_cycle(0, 1'b1, 8'(k), ov, ofd, ow, ev, efd, ew);
            n_tests++;
            if (ov !== ev || ofd !== efd || ow !== ew) begin
                n_fail++;
                $display("FAIL gaps k=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                         k, ov, ofd, ow, ev, efd, ew);
            end
            if (ov) np++;
        end
        n_tests++;
        if (np !== 4) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d windows, want 4", np);
        end
    endtask

    task automatic test_back_to_back();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew, f2_first;
        int np = 0;
        f2_first = '0;
        for (int k = 0; k < 32; k++) begin
            drive_cycle(0, 1'b1, (k < 16) ? 8'(k) : 8'(100 + k - 16), ov, ofd, ow, ev, efd, ew);
            n_tests++;
            if (ov !== ev || ofd !== efd || ow !== ew) begin
                n_fail++;
                $display("FAIL b2b k=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                         k, ov, ofd, ow, ev, efd, ew);
            end
            if (ov) begin
                if (np == 4) f2_first = ow;
                np++;
            end
        end
        n_tests++;
        if (f2_first !== 72'h64_65_66_68_69_6A_6C_6D_6E) begin
            n_fail++;
            $display("FAIL b2b_frame2_first: got %h, want 646566686 96a6c6d6e", f2_first);
        end
    endtask

    task automatic test_negative();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew, first_w;
        logic signed [7:0] px;
        int np = 0;
        first_w = '0;
        for (int k = 0; k < 16; k++) begin
            px = (k == 10) ? 8'sh7F : 8'sh80;
            drive_cycle(0, 1'b1, px, ov, ofd, ow, ev, efd, ew);
            n_tests++;
            if (ov !== ev || ofd !== efd || ow !== ew) begin
                n_fail++;
                $display("FAIL negative k=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                         k, ov, ofd, ow, ev, efd, ew);
            end
            if (ov) begin
                if (np == 0) first_w = ow;
                np++;
            end
        end
        n_tests++;
        if (first_w !== 72'h80_80_80_80_80_80_80_80_7F) begin
            n_fail++;
            $display("FAIL negative_first: got %h, want 8080808080808080 7f", first_w);
        end
    endtask

    task automatic test_reset_mid();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew, first_w;
        int cuts[2] = '{7, 11};
        int np;
        for (int ci = 0; ci < 2; ci++) begin
            for (int k = 0; k <= cuts[ci]; k++)
                drive_cycle(0, 1'b1, 8'(k), ov, ofd, ow, ev, efd, ew);
            #2 rst_n = 1'b0;
            #1;
            n_tests++;
            if (a_vo !== 1'b0 || a_fd !== 1'b0 || a_win !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_async cut=%0d: got v=%0b fd=%0b win=%h, want 0 0 0",
                         cuts[ci], a_vo, a_fd, a_win);
            end
            va = 1'b1;
            da = 8'sd55;
            @(posedge clk);
            #1;
            va = 1'b0;
            n_tests++;
            if (a_vo !== 1'b0 || a_fd !== 1'b0 || a_win !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_held cut=%0d: got v=%0b fd=%0b win=%h, want 0 0 0",
                         cuts[ci], a_vo, a_fd, a_win);
            end
            #3 rst_n = 1'b1;
            model_reset();
            np = 0;
            first_w = '0;
            for (int k = 0; k < 16; k++) begin
                drive_cycle(0, 1'b1, 8'(k), ov, ofd, ow, ev, efd, ew);
                n_tests++;
                if (ov !== ev || ofd !== efd || ow !== ew) begin
                    n_fail++;
                    $display("FAIL reset_mid_rerun k=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                             k, ov, ofd, ow, ev, efd, ew);
                end
                if (ov) begin
                    if (np == 0) first_w = ow;
                    np++;
                end
            end
            n_tests++;
            if (np !== 4 || first_w !== 72'h00_01_02_04_05_06_08_09_0A) begin
                n_fail++;
                $display("FAIL reset_mid_result cut=%0d: got %0d windows first=%h, want 4 first=00010204050608090a",
                         cuts[ci], np, first_w);
            end
        end
    endtask

    task automatic test_random();
        bit ov, ofd, ev, efd;
        logic [71:0] ow, ew;
        bit v;
        int np [2];
        int acc [2];
        int want [2] = '{8, 12};
        np = '{0, 0};
        acc = '{0, 0};
        for (int id = 0; id < 2; id++) begin
            while (acc[id] < gw(id) * gh(id) * ((id == 0) ? 2 : 3)) begin
                v = ($urandom_range(0, 3) != 0);
                drive_cycle(id, v, 8'($urandom), ov, ofd, ow, ev, efd, ew);
                n_tests++;
                if (ov !== ev || ofd !== efd || ow !== ew) begin
                    n_fail++;
                    $display("FAIL random id=%0d n=%0d: got v=%0b fd=%0b win=%h, want v=%0b fd=%0b win=%h",
                             id, acc[id], ov, ofd, ow, ev, efd, ew);
                end
                if (v) acc[id]++;
                if (ov) np[id]++;
            end
            n_tests++;
            if (np[id] !== want[id]) begin
                n_fail++;
                $display("FAIL random_count id=%0d: got %0d windows, want %0d", id, np[id], want[id]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        va = 1'b0;
        vb = 1'b0;
        da = '0;
        db = '0;
        model_reset();
        test_reset();
        test_stride1();
        test_stride2();
        test_gaps();
        test_back_to_back();
        test_negative();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
